load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the core's execute stage (ALU address, rs2 store data, funct3) and a handshaked data-memory bus. It replaces the zero-latency data memory port with a req/ack interface. It generates byte enables and lane-replicated store data, and extracts and sign- or zero-extends load data. It stalls the core until the access completes and reports misalignment, illegal funct3 and bus timeout.

## Interface
- TIMEOUT, 16: maximum cycles with mem_req high before abort (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- start  in  1  core requests an access; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code
- addr  in  32  byte address (ALU result)
- store_data  in  32  rs2 value
- stall  out  1  combinational; core must hold its PC and register write
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result, valid when done && !is_store_q && no error
- misaligned  out  1  with done: address not aligned to the access width
- fault  out  1  with done: illegal funct3 or bus timeout
- mem_req  out  1  bus request, held until ack or timeout
- mem_we  out  1  write enable
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  slave completion; rdata valid the same cycle
- mem_rdata  in  32  read word

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, start=1, funct3 legal and aligned: latch is_store, funct3 and addr[1:0]; drive bus registers; go to WAIT.
- IDLE, start=1, misaligned: go to RESP with misaligned=1. No bus activity.
- IDLE, start=1, illegal funct3: go to RESP with fault=1. No bus activity.
- Misaligned means: halfword with addr[0]≠0, or word with addr[1:0]≠0.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Byte enables: SB → mem_be = 1<<addr[1:0]; SH → 0011 or 1100; SW and all loads → 1111.
- Store data: SB replicates store_data[7:0] ×4; SH replicates [15:0] ×2; SW passes through.
- WAIT, mem_ack=1: on a load, register the extracted lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Drop mem_req. Go to RESP.
- WAIT, no ack after TIMEOUT cycles: drop mem_req, go to RESP with fault=1.
- WAIT, ack on the same cycle as the timeout: ack wins and there is no fault.
- RESP: done=1 for exactly one cycle, error flags valid, then IDLE. start is ignored in RESP.
- mem_ack outside WAIT is ignored.
- load_data updates only on a successful load and holds its value otherwise.
- stall = (state==IDLE && start) || state==WAIT. stall is low in RESP, so the core retires on the done cycle.

## Timing
- Reset: state IDLE; all outputs 0, including load_data and mem_addr; timeout counter 0.
- Reset during WAIT: mem_req goes low on the next edge and the access is abandoned. The slave must tolerate this.
- Start accepted at edge 0: mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and valid from cycle 1. They stay stable until ack.
- Ack sampled at edge k (k ≥ 1): done is high in cycle k+1.
- Minimum latency, ack in cycle 1: start cycle 0, done cycle 2.
- Error without bus access: done in cycle 1.
- Timeout counter increments each WAIT cycle. Abort happens at the edge where the count reaches TIMEOUT, so done falls in cycle TIMEOUT+1.
- Back-to-back: the next start is earliest in the cycle after done.

## Structure
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum;
  - the byte-enable patterns.
- Sub-module lsu_align: combinational. Covers store replication, byte-enable generation, load lane extraction and extension, and the misaligned/illegal checks. It is shared with a later pipelined core.

## Test plan
- SW addr 0x104, data 0xDEADBEEF, ack in cycle 1 → mem_addr 0x104, be 1111, wdata 0xDEADBEEF; done in cycle 2; no flags.
- Memory word 0x80FF7F01 at 0x200. LB at 0x203 → 0xFFFFFF80. LBU at 0x203 → 0x00000080. LH at 0x202 → 0xFFFF80FF. LHU at 0x200 → 0x00007F01.
- SB addr 0x0A, data 0x12345678 → be 0100, wdata 0x78787878. SH addr 0x0E → be 1100, wdata 0x56785678.
- LW at 0x101 → done in cycle 1 with misaligned=1, mem_req never high. funct3=011 load → done in cycle 1 with fault=1.
- No ack with TIMEOUT=16 → mem_req high for cycles 1–16, done with fault in cycle 17. Repeat with ack in cycle 16 → no fault.
- reset low during WAIT → mem_req 0 next cycle, no done. Late ack is ignored. A start after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and byte-enable patterns.
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte enables, load extraction/extension and access checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic            misaligned_c,
  output logic            illegal_c,
  output logic [XLEN-1:0] load_c
);

  logic       illegal_v;
  logic [7:0] lane_b;
  logic [15:0] lane_h;

  // An illegal code is reported as a fault, never as misaligned.
  always_comb begin : access_check
    illegal_v    = 1'b0;
    misaligned_c = 1'b0;
    if (is_store) illegal_v = !(funct3 inside {F3_B, F3_H, F3_W});
    else          illegal_v = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    if (!illegal_v) begin
      case (funct3)
        F3_H, F3_HU: misaligned_c = addr_lo[0];
        F3_W:        misaligned_c = (addr_lo != 2'b00);
        default:     misaligned_c = 1'b0;
      endcase
    end
    illegal_c = illegal_v;
  end

  always_comb begin : store_lanes
    be_c    = BE_ALL;
    wdata_c = store_data;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          be_c    = BE_BYTE << addr_lo;
          wdata_c = {4{store_data[7:0]}};
        end
        F3_H: begin
          be_c    = addr_lo[1] ? BE_HI : BE_LO;
          wdata_c = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin : load_lanes
    case (ld_addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    load_c = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_c = {24'd0, lane_b};
      F3_H:    load_c = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_c = {16'd0, lane_h};
      default: load_c = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit bridging the execute stage to a req/ack data-memory bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            fault,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lo_q, lo_d;
  logic              req_d, we_d, done_d, mis_d, fault_d;
  logic [XLEN-1:0]   addr_d, wdata_d, load_d;
  logic [3:0]        be_d;

  logic [3:0]        be_c;
  logic [XLEN-1:0]   wdata_c, load_c;
  logic              misaligned_c, illegal_c;

  lsu_align u_align (
    .is_store     (is_store),
    .funct3       (funct3),
    .addr_lo      (addr[1:0]),
    .store_data   (store_data),
    .ld_funct3    (funct3_q),
    .ld_addr_lo   (lo_q),
    .rdata        (mem_rdata),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .misaligned_c (misaligned_c),
    .illegal_c    (illegal_c),
    .load_c       (load_c)
  );

  // Low in RESP so the core retires on the done cycle.
  assign stall = ((state_q == S_IDLE) && start) || (state_q == S_WAIT);

  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    lo_d       = lo_q;
    req_d      = mem_req;
    we_d       = mem_we;
    addr_d     = mem_addr;
    be_d       = mem_be;
    wdata_d    = mem_wdata;
    load_d     = load_data;
    done_d     = 1'b0;
    mis_d      = 1'b0;
    fault_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (illegal_c) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else if (misaligned_c) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            is_store_d = is_store;
            funct3_d   = funct3;
            lo_d       = addr[1:0];
            req_d      = 1'b1;
            we_d       = is_store;
            addr_d     = {addr[XLEN-1:2], 2'b00};
            be_d       = be_c;
            wdata_d    = is_store ? wdata_c : '0;
          end
        end
      end
      S_WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (mem_ack) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
          if (!is_store_q) load_d = load_c;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          fault_d = 1'b1;
          req_d   = 1'b0;
          we_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin : regs
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      lo_q       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      lo_q       <= lo_d;
      mem_req    <= req_d;
      mem_we     <= we_d;
      mem_addr   <= addr_d;
      mem_be     <= be_d;
      mem_wdata  <= wdata_d;
      load_data  <= load_d;
      done       <= done_d;
      misaligned <= mis_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; cycle 0 is the cycle start is driven high.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, misaligned, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .stall(stall), .done(done),
    .load_data(load_data), .misaligned(misaligned), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Drives one access from posedge+1; acks in cycle ack_at (-1 = never); records what the bus saw.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a, sd, rd,
                            input int ack_at, input int max_cyc,
                            output int done_cyc, output int req_first, output int req_last,
                            output logic [31:0] cap_addr, output logic [3:0] cap_be,
                            output logic [31:0] cap_wdata, output logic cap_we,
                            output logic mis, output logic flt, output logic stall0,
                            output logic [31:0] ld);
    done_cyc = -1; req_first = -1; req_last = -1;
    cap_addr = 'x; cap_be = 'x; cap_wdata = 'x; cap_we = 1'bx;
    mis = 1'bx; flt = 1'bx; stall0 = 1'bx; ld = 'x;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    for (int c = 0; c <= max_cyc; c++) begin
      mem_ack = (c == ack_at);
      mem_rdata = rd;
      @(negedge clk);
      if (c == 0) stall0 = stall;
      if (mem_req) begin
        if (req_first < 0) req_first = c;
        req_last = c;
      end
      if (c == 1) begin
        cap_addr = mem_addr; cap_be = mem_be; cap_wdata = mem_wdata; cap_we = mem_we;
      end
      if (done && done_cyc < 0) begin
        done_cyc = c; mis = misaligned; flt = fault; ld = load_data;
      end
      @(posedge clk); #1;
      start = 1'b0; mem_ack = 1'b0;
      if (done_cyc >= 0) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", mem_req); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (load_data !== 32'h0) $display("FAIL reset_load_data got %h want 0", load_data); else passed++;
    checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0)
      $display("FAIL reset_bus got %h/%h/%h want 0/0/0", mem_addr, mem_be, mem_wdata); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sw();
    int dc, rf, rl; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    run_access(1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'h0, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 2) $display("FAIL sw_done_cycle got %0d want 2", dc); else passed++;
    checks++; if (ca !== 32'h104 || cb !== 4'b1111 || cw !== 32'hDEADBEEF || we !== 1'b1)
      $display("FAIL sw_bus got addr %h be %b wdata %h we %b want 104 1111 deadbeef 1", ca, cb, cw, we); else passed++;
    checks++; if (mi !== 1'b0 || fl !== 1'b0) $display("FAIL sw_flags got %b%b want 00", mi, fl); else passed++;
    checks++; if (s0 !== 1'b1) $display("FAIL sw_stall_c0 got %b want 1", s0); else passed++;
    checks++; if (rf !== 1 || rl !== 1) $display("FAIL sw_req_window got %0d..%0d want 1..1", rf, rl); else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL sw_done_one_cycle got %b want 0", done); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_loads();
    int dc, rf, rl; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    run_access(1'b0, F3_B, 32'h203, 32'h0, 32'h80FF7F01, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (ld !== 32'hFFFFFF80) $display("FAIL lb got %h want ffffff80", ld); else passed++;
    checks++; if (ca !== 32'h200 || cb !== 4'b1111 || we !== 1'b0)
      $display("FAIL lb_bus got addr %h be %b we %b want 200 1111 0", ca, cb, we); else passed++;
    run_access(1'b0, F3_BU, 32'h203, 32'h0, 32'h80FF7F01, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (ld !== 32'h00000080) $display("FAIL lbu got %h want 00000080", ld); else passed++;
    run_access(1'b0, F3_H, 32'h202, 32'h0, 32'h80FF7F01, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (ld !== 32'hFFFF80FF) $display("FAIL lh got %h want ffff80ff", ld); else passed++;
    run_access(1'b0, F3_HU, 32'h200, 32'h0, 32'h80FF7F01, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (ld !== 32'h00007F01) $display("FAIL lhu got %h want 00007f01", ld); else passed++;
    checks++; if (dc !== 2) $display("FAIL lhu_done_cycle got %0d want 2", dc); else passed++;
  endtask

  task automatic test_store_lanes();
    int dc, rf, rl; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    run_access(1'b1, F3_B, 32'h0A, 32'h12345678, 32'h0, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (ca !== 32'h08 || cb !== 4'b0100 || cw !== 32'h78787878)
      $display("FAIL sb got addr %h be %b wdata %h want 08 0100 78787878", ca, cb, cw); else passed++;
    run_access(1'b1, F3_H, 32'h0E, 32'h12345678, 32'h0, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (ca !== 32'h0C || cb !== 4'b1100 || cw !== 32'h56785678)
      $display("FAIL sh got addr %h be %b wdata %h want 0c 1100 56785678", ca, cb, cw); else passed++;
    checks++; if (ld !== 32'h00007F01) $display("FAIL store_keeps_load_data got %h want 00007f01", ld); else passed++;
  endtask

  task automatic test_errors();
    int dc, rf, rl; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    run_access(1'b0, F3_W, 32'h101, 32'h0, 32'hAAAAAAAA, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 1 || mi !== 1'b1 || fl !== 1'b0)
      $display("FAIL lw_misaligned got cyc %0d mis %b flt %b want 1 1 0", dc, mi, fl); else passed++;
    checks++; if (rf !== -1) $display("FAIL lw_misaligned_no_req got first req %0d want -1", rf); else passed++;
    checks++; if (ld !== 32'h00007F01) $display("FAIL misaligned_keeps_load_data got %h want 00007f01", ld); else passed++;
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 32'hAAAAAAAA, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 1 || mi !== 1'b0 || fl !== 1'b1 || rf !== -1)
      $display("FAIL illegal_load got cyc %0d mis %b flt %b req %0d want 1 0 1 -1", dc, mi, fl, rf); else passed++;
    run_access(1'b1, F3_BU, 32'h100, 32'h0, 32'h0, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 1 || fl !== 1'b1 || rf !== -1)
      $display("FAIL illegal_store got cyc %0d flt %b req %0d want 1 1 -1", dc, fl, rf); else passed++;
    run_access(1'b1, F3_H, 32'h0B, 32'h0, 32'h0, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 1 || mi !== 1'b1 || fl !== 1'b0)
      $display("FAIL sh_misaligned got cyc %0d mis %b flt %b want 1 1 0", dc, mi, fl); else passed++;
  endtask

  task automatic test_timeout();
    int dc, rf, rl; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    run_access(1'b0, F3_W, 32'h400, 32'h0, 32'h13572468, -1, 40, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 17 || fl !== 1'b1 || mi !== 1'b0)
      $display("FAIL timeout got cyc %0d flt %b mis %b want 17 1 0", dc, fl, mi); else passed++;
    checks++; if (rf !== 1 || rl !== 16) $display("FAIL timeout_req_window got %0d..%0d want 1..16", rf, rl); else passed++;
    checks++; if (ld !== 32'h00007F01) $display("FAIL timeout_keeps_load_data got %h want 00007f01", ld); else passed++;
    run_access(1'b0, F3_W, 32'h400, 32'h0, 32'h13572468, 16, 40, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 17 || fl !== 1'b0) $display("FAIL ack_at_timeout got cyc %0d flt %b want 17 0", dc, fl); else passed++;
    checks++; if (ld !== 32'h13572468) $display("FAIL ack_at_timeout_data got %h want 13572468", ld); else passed++;
  endtask

  task automatic test_ack_idle();
    int seen = 0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      if (done || mem_req) seen++;
    end
    mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++; if (seen !== 0) $display("FAIL ack_in_idle got %0d active cycles want 0", seen); else passed++;
    checks++; if (load_data !== 32'h13572468) $display("FAIL ack_in_idle_data got %h want 13572468", load_data); else passed++;
  endtask

  task automatic test_reset_in_wait();
    int dc, rf, rl, seen; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    start = 1'b1; is_store = 1'b0; funct3 = F3_W; addr = 32'h300; mem_rdata = 32'h11111111;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) $display("FAIL wait_req got %b want 1", mem_req); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_in_wait got req %b done %b want 0 0", mem_req, done); else passed++;
    reset = 1'b1; mem_ack = 1'b1;
    @(posedge clk); #1; mem_ack = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++; if (seen !== 0 || load_data !== 32'h0)
      $display("FAIL late_ack got done %0d data %h want 0 00000000", seen, load_data); else passed++;
    @(posedge clk); #1;
    run_access(1'b0, F3_W, 32'h300, 32'h0, 32'hCAFEF00D, 2, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 3 || fl !== 1'b0 || ld !== 32'hCAFEF00D)
      $display("FAIL after_reset got cyc %0d flt %b data %h want 3 0 cafef00d", dc, fl, ld); else passed++;
  endtask

  task automatic test_back_to_back();
    int dc, rf, rl; logic [31:0] ca, cw, ld; logic [3:0] cb; logic we, mi, fl, s0;
    run_access(1'b1, F3_W, 32'h10, 32'h01020304, 32'h0, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    run_access(1'b0, F3_BU, 32'h11, 32'h0, 32'h0000A500, 1, 10, dc, rf, rl, ca, cb, cw, we, mi, fl, s0, ld);
    checks++; if (dc !== 2 || ld !== 32'h000000A5)
      $display("FAIL back_to_back got cyc %0d data %h want 2 000000a5", dc, ld); else passed++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_loads();
    test_store_lanes();
    test_errors();
    test_timeout();
    test_ack_idle();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
